// File: rtl/vga_pkg.sv
// Shared constants and state type for the tiled 640x480 display path.
`timescale 1ns/1ps
package vga_pkg;

    localparam int HLEFT     = 144;
    localparam int VTOP      = 31;
    localparam int COLS      = 80;
    localparam int ROWS      = 60;
    localparam int MAP_DEPTH = COLS * ROWS;
    localparam int MAP_AW    = 13;
    localparam int TILE_W    = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/tile_map_ram.sv
// Single-port tile-index map storage with a registered read.
// A read in the same cycle as a write to the same address returns the old contents.
`timescale 1ns/1ps
module tile_map_ram
    import vga_pkg::*;
(
    input  logic              clk_i,
    input  logic [MAP_AW-1:0] addr_i,
    input  logic              we_i,
    input  logic [TILE_W-1:0] wdata_i,
    output logic [TILE_W-1:0] rdata_o
);

    logic [TILE_W-1:0] mem [MAP_DEPTH];

    // Write when enabled and always read the pre-write contents one cycle later.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/tile_map_scheduler.sv
// Tile-map scheduler: prefetches the tile index for the next 8-pixel column
// ahead of the raster, commits it on the tile boundary, and shares the map
// RAM between that prefetch, a post-reset clear sweep and a buffered host writer.
`timescale 1ns/1ps
module tile_map_scheduler
    import vga_pkg::*;
#(
    parameter int HLEFT          = vga_pkg::HLEFT,
    parameter int VTOP           = vga_pkg::VTOP,
    parameter int LEAD           = 1,
    parameter int COLS           = vga_pkg::COLS,
    parameter int ROWS           = vga_pkg::ROWS,
    parameter int CLEAR_ON_RESET = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          hcount,
    input  logic [9:0]          vcount,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [MAP_AW-1:0]   wr_addr,
    input  logic [TILE_W-1:0]   wr_data,
    output logic                wr_err,
    output logic                busy,
    output logic [TILE_W-1:0]   tselect
);

    localparam logic [9:0]        HLEFT10     = 10'(HLEFT);
    localparam logic [9:0]        VTOP10      = 10'(VTOP);
    localparam logic [9:0]        LEAD10      = 10'(LEAD);
    localparam logic [9:0]        VIS_LINES   = 10'(ROWS * 8);
    localparam logic [6:0]        COLS7       = 7'(COLS);
    localparam logic [MAP_AW-1:0] DEPTH_A     = MAP_AW'(COLS * ROWS);
    localparam logic [MAP_AW-1:0] LAST_A      = DEPTH_A - 1'b1;
    localparam state_e            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_e              state_q, state_d;
    logic [MAP_AW-1:0]   clrCnt_q, clrCnt_d;
    logic                holdValid_q, holdValid_d;
    logic [MAP_AW-1:0]   holdAddr_q, holdAddr_d;
    logic [TILE_W-1:0]   holdData_q, holdData_d;
    logic                fetchPend_q;
    logic [TILE_W-1:0]   nextTile_q;
    logic [TILE_W-1:0]   tselect_q;
    logic                wrErr_q;

    logic [9:0]          ax;
    logic [9:0]          ay;
    logic [5:0]          row;
    logic [6:0]          nc;
    logic                fetchSlot;
    logic [MAP_AW-1:0]   fetchAddr;
    logic                accept;
    logic                inRange;
    logic                drain;

    logic [MAP_AW-1:0]   ramAddr;
    logic                ramWe;
    logic [TILE_W-1:0]   ramWdata;
    logic [TILE_W-1:0]   ramRdata;

    assign ax        = hcount - HLEFT10 + LEAD10;
    assign ay        = vcount - VTOP10;
    assign row       = ay[8:3];
    assign nc        = ax[9:3] + 7'd1;
    assign fetchSlot = (ax[2:0] == 3'd3) && (state_q == RUN) && (ay < VIS_LINES) && (nc < COLS7);
    assign fetchAddr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, nc};

    assign wr_ready  = !rst && (state_q == RUN) && !holdValid_q;
    assign accept    = wr_valid && wr_ready;
    assign inRange   = wr_addr < DEPTH_A;
    assign drain     = holdValid_q && !fetchSlot && !rst;

    assign busy      = (state_q == CLEAR);
    assign wr_err    = wrErr_q;
    assign tselect   = tselect_q;

    // RAM port arbitration: clear sweep, then video fetch, then host drain.
    always_comb begin
        ramAddr  = fetchAddr;
        ramWe    = 1'b0;
        ramWdata = '0;
        if (state_q == CLEAR) begin
            ramAddr = clrCnt_q;
            ramWe   = !rst;
        end else if (!fetchSlot && drain) begin
            ramAddr  = holdAddr_q;
            ramWe    = 1'b1;
            ramWdata = holdData_q;
        end
    end

    // Next-state for the clear sweep counter, FSM and host holding buffer.
    always_comb begin
        state_d     = state_q;
        clrCnt_d    = clrCnt_q;
        holdValid_d = holdValid_q;
        holdAddr_d  = holdAddr_q;
        holdData_d  = holdData_q;
        if (state_q == CLEAR) begin
            clrCnt_d = clrCnt_q + 1'b1;
            if (clrCnt_q == LAST_A) begin
                state_d  = RUN;
                clrCnt_d = '0;
            end
        end
        if (drain) begin
            holdValid_d = 1'b0;
        end
        if (accept && inRange) begin
            holdValid_d = 1'b1;
            holdAddr_d  = wr_addr;
            holdData_d  = wr_data;
        end
    end

    // State registers plus the fetch / capture / commit pipeline for tselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            clrCnt_q    <= '0;
            holdValid_q <= 1'b0;
            holdAddr_q  <= '0;
            holdData_q  <= '0;
            fetchPend_q <= 1'b0;
            nextTile_q  <= '0;
            tselect_q   <= '0;
            wrErr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clrCnt_q    <= clrCnt_d;
            holdValid_q <= holdValid_d;
            holdAddr_q  <= holdAddr_d;
            holdData_q  <= holdData_d;
            fetchPend_q <= fetchSlot;
            wrErr_q     <= accept && !inRange;
            if (ax[2:0] == 3'd4) begin
                nextTile_q <= fetchPend_q ? ramRdata : '0;
            end
            if (ax[2:0] == 3'd7) begin
                tselect_q <= nextTile_q;
            end
        end
    end

    tile_map_ram u_ram (
        .clk_i   (clk),
        .addr_i  (ramAddr),
        .we_i    (ramWe),
        .wdata_i (ramWdata),
        .rdata_o (ramRdata)
    );

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Scoreboard bench for tile_map_scheduler: a per-pixel map model predicts tselect
// and each accepted write predicts wr_err; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tile_map_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = 10'd600;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [12:0] wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        wr_err;
    logic        busy;
    logic [3:0]  tselect;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int h;
        int v;
        int exp;
    } pix_t;

    pix_t tselQ[$];
    int   errQ[$];
    int   map[4800];
    bit   acceptPrev = 1'b0;
    pix_t monPix;
    int   monErr;

    always #5 clk = ~clk;

    tile_map_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .hcount   (hcount),
        .vcount   (vcount),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .busy     (busy),
        .tselect  (tselect)
    );

    // Tile shown at a pixel: column c occupies hcount 143+8c .. 150+8c of visible rows.
    function automatic int expectedTile(int h, int v);
        int ax, ay, c;
        ax = (h - 143) & 1023;
        ay = (v - 31) & 1023;
        c  = ax / 8;
        if (ay < 480 && c < 80) return map[(ay / 8) * 80 + c];
        return 0;
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the predicted pixel each cycle and wr_err after every accept.
    always @(negedge clk) begin
        if (tselQ.size() > 0) begin
            monPix = tselQ.pop_front();
            vectors++;
            if (tselect != monPix.exp[3:0]) begin
                miscompares++;
                $display("[TB] FAIL tselect h=%0d v=%0d: got %0d expected %0d",
                         monPix.h, monPix.v, tselect, monPix.exp);
            end
        end
        if (acceptPrev) begin
            monErr = (errQ.size() > 0) ? errQ.pop_front() : 0;
            checkOutput("wr_err", int'(wr_err), monErr);
        end else if (wr_err) begin
            checkOutput("wr_err_spurious", 1, 0);
        end
        acceptPrev = wr_valid && wr_ready;
    end

    // Host write through the valid/ready handshake with a bounded wait.
    task automatic applyStimulus(int addr, int data);
        int  n;
        bit  seen;
        wr_valid = 1'b1;
        wr_addr  = 13'(addr);
        wr_data  = 4'(data);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (wr_ready) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            checkOutput("wr_ready_timeout", 0, 1);
            tick();
            wr_valid = 1'b0;
            return;
        end
        errQ.push_back((addr >= 4800) ? 1 : 0);
        if (addr < 4800) map[addr] = data;
        tick();
        wr_valid = 1'b0;
    endtask

    // Drive one line from ax=1016 up to hEnd, optionally injecting a write at collideH.
    task automatic sweepLine(int v, int hEnd, int collideH, int cAddr, int cData);
        pix_t p;
        for (int h = 135; h <= hEnd; h++) begin
            tick();
            hcount   = 10'(h);
            vcount   = 10'(v);
            wr_valid = 1'b0;
            if (h >= 143) begin
                p.h = h;
                p.v = v;
                p.exp = expectedTile(h, v);
                tselQ.push_back(p);
            end
            if (collideH >= 0) begin
                if (h == collideH) begin
                    checkOutput("collide_ready_pre", int'(wr_ready), 1);
                    if (wr_ready) begin
                        wr_valid = 1'b1;
                        wr_addr  = 13'(cAddr);
                        wr_data  = 4'(cData);
                        errQ.push_back(0);
                    end
                end else if (h == collideH + 1 || h == collideH + 2) begin
                    checkOutput("collide_ready_low", int'(wr_ready), 0);
                end else if (h == collideH + 3) begin
                    checkOutput("collide_ready_back", int'(wr_ready), 1);
                end
            end
        end
    endtask

    // Count busy cycles after reset release; wr_ready must stay low meanwhile.
    task automatic measureClear(string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (busy && n < 6000) begin
            if (wr_ready) bad++;
            n++;
            tick();
        end
        checkOutput({tag, "_len"}, n, 4800);
        checkOutput({tag, "_ready_while_busy"}, bad, 0);
        checkOutput({tag, "_busy_after"}, int'(busy), 0);
        checkOutput({tag, "_ready_after"}, int'(wr_ready), 1);
        foreach (map[i]) map[i] = 0;
    endtask

    initial begin
        int rows[4];

        // Reset values
        repeat (3) tick();
        checkOutput("reset_tselect", int'(tselect), 0);
        checkOutput("reset_wr_err", int'(wr_err), 0);
        checkOutput("reset_busy", int'(busy), 1);
        checkOutput("reset_wr_ready", int'(wr_ready), 0);

        // Clear sweep and full-frame zero check
        rst = 1'b0;
        measureClear("clear");
        for (int r = 0; r < 60; r++) begin
            sweepLine(31 + 8 * r + int'($urandom_range(0, 7)), 800, -1, 0, 0);
        end

        // Basic display, including hblank prefetch of column 0
        vcount = 10'd600;
        applyStimulus(0, 5);
        applyStimulus(1, 9);
        applyStimulus(79, 3);
        applyStimulus(5, 2);
        applyStimulus(2, 12);
        sweepLine(31, 1023, -1, 0, 0);

        // Collision: write to column 5 drains one cycle after the fetch slot
        sweepLine(31, 1023, 177, 5, 14);
        map[5] = 14;
        sweepLine(32, 1023, -1, 0, 0);

        // Range error and last entry
        vcount = 10'd600;
        applyStimulus(4800, 7);
        applyStimulus(4799, 6);
        sweepLine(31 + 472, 1023, -1, 0, 0);
        sweepLine(31 + 479, 1023, -1, 0, 0);
        sweepLine(31, 1023, -1, 0, 0);

        // Blank line below the visible area
        sweepLine(31 + 480, 1023, -1, 0, 0);

        // Random writes into a few rows plus random addresses across the space
        vcount = 10'd600;
        for (int k = 0; k < 4; k++) rows[k] = int'($urandom_range(1, 58));
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 12; j++) begin
                applyStimulus(rows[k] * 80 + int'($urandom_range(0, 79)), int'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        for (int j = 0; j < 8; j++) begin
            applyStimulus(int'($urandom_range(0, 8191)), int'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 4; k++) begin
            sweepLine(31 + 8 * rows[k] + int'($urandom_range(0, 7)), 1023, -1, 0, 0);
        end

        // Reset mid-write while a nonzero tile is on screen
        vcount = 10'd600;
        applyStimulus(2, 12);
        applyStimulus(100, 3);
        sweepLine(31, 162, -1, 0, 0);
        repeat (2) tick();
        checkOutput("midrst_ready_pre", int'(wr_ready), 1);
        if (wr_ready) begin
            wr_valid = 1'b1;
            wr_addr  = 13'd100;
            wr_data  = 4'd10;
            errQ.push_back(0);
        end
        tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("midrst_tselect", int'(tselect), 0);
        checkOutput("midrst_wr_ready", int'(wr_ready), 0);
        checkOutput("midrst_busy", int'(busy), 1);
        rst = 1'b0;
        measureClear("reclear");
        sweepLine(31 + 8, 1023, -1, 0, 0);
        sweepLine(31, 1023, -1, 0, 0);

        repeat (3) tick();
        checkOutput("errq_drained", errQ.size(), 0);
        checkOutput("tselq_drained", tselQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
